// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes
// and the branch-offset helper.
package ifetch_unit_pkg;

    typedef enum logic [1:0] {
        PC_MUX_SEL_NEWPC  = 2'b00,
        PC_MUX_SEL_BRANCH = 2'b01,
        PC_MUX_SEL_JUMP   = 2'b10,
        PC_MUX_SEL_JR     = 2'b11
    } pc_sel_e;

    // Word offset from a 16-bit immediate: sign-extend, then scale by 4.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// Combinational next-PC computation from the decoder's select code.
// Only instr[25:0] is needed: branch immediates and jump indices live there.
module ifetch_unit_npc_calc
    import ifetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr_idx,
    input  logic [1:0]  pc_sel,
    input  logic        br_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel_e'(pc_sel))
            PC_MUX_SEL_NEWPC:  next_pc = pc_plus4;
            PC_MUX_SEL_BRANCH: next_pc = br_taken ? pc_plus4 + br_offset(instr_idx[15:0]) : pc_plus4;
            PC_MUX_SEL_JUMP:   next_pc = {pc_plus4[31:28], instr_idx, 2'b00};
            PC_MUX_SEL_JR:     next_pc = jr_target;
            default:           next_pc = pc_plus4;
        endcase
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over req/gnt, issues one
// instruction at a time and updates the PC when execute completes.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic [5:0]       func,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             ex_done,
    input  logic [1:0]       pc_sel,
    input  logic             br_taken,
    input  logic [31:0]      jr_target,
    output logic             addr_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             instr_valid_q, instr_valid_d;
    logic             imem_req_q, imem_req_d;
    logic             addr_err_q, addr_err_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0]      next_pc;
    logic             misaligned;

    ifetch_unit_npc_calc u_npc_calc (
        .pc         (pc_q),
        .instr_idx  (instr_q[25:0]),
        .pc_sel     (pc_sel),
        .br_taken   (br_taken),
        .jr_target  (jr_target),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // imem_req and instr_valid are registered: they are set on the edge
    // that enters FETCH/ISSUE rather than decoded from state_q.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        imem_req_d    = imem_req_q;
        addr_err_d    = addr_err_q;
        count_d       = count_q;
        case (state_q)
            S_IDLE: begin
                state_d    = S_FETCH;
                imem_req_d = 1'b1;
            end
            S_FETCH: begin
                if (imem_gnt) begin
                    instr_d       = imem_rdata;
                    imem_req_d    = 1'b0;
                    instr_valid_d = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ex_done) begin
                    count_d       = count_q + CNT_W'(1);
                    instr_valid_d = 1'b0;
                    if (misaligned) begin
                        addr_err_d = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        pc_d       = next_pc;
                        imem_req_d = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            addr_err_q    <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            addr_err_q    <= addr_err_d;
            count_q       <= count_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign func        = instr_q[5:0];
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign addr_err    = addr_err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed plus randomized bench for ifetch_unit against a transaction-level
// model of PC, instruction and retire count.
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ex_done;
    logic [1:0]  pc_sel;
    logic        br_taken;
    logic [31:0] jr_target;
    logic        addr_err;
    logic [31:0] instr_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;

    ifetch_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .func        (func),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .ex_done     (ex_done),
        .pc_sel      (pc_sel),
        .br_taken    (br_taken),
        .jr_target   (jr_target),
        .addr_err    (addr_err),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rule, written as plain address arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                               input logic [1:0] sel, input logic br,
                                               input logic [31:0] jr);
        int signed imm;
        imm = int'($signed(ins[15:0]));
        case (sel)
            2'd0:    return cur + 32'd4;
            2'd1:    return br ? cur + 32'd4 + 32'(imm * 4) : cur + 32'd4;
            2'd2:    return ((cur + 32'd4) & 32'hF000_0000) + 32'(ins[25:0]) * 32'd4;
            default: return jr;
        endcase
    endfunction

    // Entered at a negedge where the unit is fetching m_pc; exits at the
    // negedge where the fetched word is issued.
    task automatic fetch(input int waits, input logic [31:0] word);
        for (int i = 0; i <= waits; i++) begin
            check("fetch_req", 32'(imem_req), 32'd1);
            check("fetch_addr", imem_addr, m_pc);
            check("fetch_valid", 32'(instr_valid), 32'd0);
            imem_gnt   = (i == waits);
            imem_rdata = (i == waits) ? word : $urandom;
            ex_done    = 1'($urandom);
            @(negedge clk);
        end
        imem_gnt   = 1'b0;
        ex_done    = 1'b0;
        imem_rdata = $urandom;
        m_instr    = word;
        check("issue_valid", 32'(instr_valid), 32'd1);
        check("issue_instr", instr, word);
        check("issue_opcode", 32'(opcode), 32'(word[31:26]));
        check("issue_func", 32'(func), 32'(word[5:0]));
        check("issue_req", 32'(imem_req), 32'd0);
        check("issue_pc", pc, m_pc);
        check("issue_pc4", pc_plus4, m_pc + 32'd4);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            imem_gnt   = 1'($urandom);
            imem_rdata = $urandom;
            @(negedge clk);
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_instr", instr, m_instr);
            check("hold_pc", pc, m_pc);
        end
        imem_gnt = 1'b0;
    endtask

    task automatic exec(input logic [1:0] sel, input logic br, input logic [31:0] jr);
        logic [31:0] nxt;
        nxt       = model_next(m_pc, m_instr, sel, br, jr);
        ex_done   = 1'b1;
        pc_sel    = sel;
        br_taken  = br;
        jr_target = jr;
        imem_gnt  = 1'($urandom);
        @(negedge clk);
        ex_done   = 1'b0;
        imem_gnt  = 1'b0;
        pc_sel    = 2'($urandom);
        br_taken  = 1'($urandom);
        jr_target = $urandom;
        m_count   = m_count + 32'd1;
        if (nxt[1:0] == 2'b00) begin
            m_pc = nxt;
            check("exec_pc", pc, m_pc);
            check("exec_req", 32'(imem_req), 32'd1);
            check("exec_addr", imem_addr, m_pc);
            check("exec_err", 32'(addr_err), 32'd0);
        end else begin
            check("halt_pc", pc, m_pc);
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_err", 32'(addr_err), 32'd1);
        end
        check("exec_valid", 32'(instr_valid), 32'd0);
        check("exec_count", instr_count, m_count);
    endtask

    initial begin
        rst        = 1'b1;
        imem_gnt   = 1'b0;
        imem_rdata = '0;
        ex_done    = 1'b0;
        pc_sel     = 2'b00;
        br_taken   = 1'b0;
        jr_target  = '0;
        m_pc       = 32'h0;
        m_instr    = 32'h0;
        m_count    = 32'h0;

        @(negedge clk);
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        check("rst_count", instr_count, 32'd0);

        rst = 1'b0;
        @(negedge clk);
        fetch(2, 32'h3403_0005);
        check("ori_opcode", 32'(opcode), 32'h0D);
        check("ori_func", 32'(func), 32'h05);
        hold(2);
        exec(2'b00, 1'b0, 32'h0);
        check("seq_pc4", pc, 32'h4);

        fetch(0, 32'h0);
        exec(2'b11, 1'b0, 32'h40);
        fetch(1, 32'h1000_FFFF);
        exec(2'b01, 1'b1, 32'h0);
        check("br_back", pc, 32'h40);
        fetch(0, 32'h1000_FFFF);
        exec(2'b01, 1'b0, 32'h0);
        check("br_not", pc, 32'h44);

        fetch(0, 32'h0);
        exec(2'b11, 1'b0, 32'h0040_0010);
        fetch(3, 32'h0810_0000);
        exec(2'b10, 1'b0, 32'h0);
        check("jump", pc, 32'h0040_0000);

        fetch(0, 32'h0);
        exec(2'b11, 1'b0, 32'hFFFF_FFFC);
        fetch(0, 32'h0);
        exec(2'b00, 1'b0, 32'h0);
        check("pc_wrap", pc, 32'h0);

        fetch(0, 32'h0);
        exec(2'b11, 1'b0, 32'h0010_0000);
        fetch(0, 32'h1000_8000);
        exec(2'b01, 1'b1, 32'h0);
        check("br_min", pc, 32'h000E_0004);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] s;
            s = 2'($urandom);
            fetch(int'($urandom_range(0, 4)), $urandom);
            hold(int'($urandom_range(0, 2)));
            exec(s, 1'($urandom), $urandom & 32'hFFFF_FFFC);
        end

        // Reset together with ex_done: no retire is counted.
        fetch(1, $urandom);
        rst     = 1'b1;
        ex_done = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        ex_done = 1'b0;
        m_pc    = 32'h0;
        m_count = 32'h0;
        check("rstex_count", instr_count, 32'd0);
        check("rstex_valid", 32'(instr_valid), 32'd0);
        check("rstex_pc", pc, 32'h0);
        @(negedge clk);

        fetch(0, 32'h0);
        exec(2'b11, 1'b0, 32'h0000_1002);
        for (int i = 0; i < 3; i++) begin
            imem_gnt   = 1'b1;
            imem_rdata = $urandom;
            ex_done    = 1'b1;
            pc_sel     = 2'b00;
            @(negedge clk);
            check("halt_hold_pc", pc, m_pc);
            check("halt_hold_count", instr_count, m_count);
            check("halt_hold_err", 32'(addr_err), 32'd1);
            check("halt_hold_req", 32'(imem_req), 32'd0);
            check("halt_hold_valid", 32'(instr_valid), 32'd0);
        end
        imem_gnt = 1'b0;
        ex_done  = 1'b0;

        rst = 1'b1;
        @(negedge clk);
        check("rst_halt_err", 32'(addr_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("refetch_req", 32'(imem_req), 32'd1);

        // Reset in FETCH coinciding with a grant: nothing is captured.
        rst        = 1'b1;
        imem_gnt   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst      = 1'b0;
        imem_gnt = 1'b0;
        check("rstgnt_instr", instr, 32'h0);
        check("rstgnt_pc", pc, 32'h0);
        check("rstgnt_req", 32'(imem_req), 32'd0);
        check("rstgnt_valid", 32'(instr_valid), 32'd0);
        check("rstgnt_err", 32'(addr_err), 32'd0);
        check("rstgnt_count", instr_count, 32'd0);
        @(negedge clk);
        m_pc    = 32'h0;
        m_count = 32'h0;
        fetch(0, 32'h3403_0005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and fetches from instruction memory through a req/gnt handshake.
- Presents the instruction, opcode and func to the decoder and execute path.
- Computes the next PC from the decoder's PC_sel code once execute signals completion; one instruction is in flight at a time.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address; equals pc
imem_gnt  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word
instr  out  32  registered instruction
opcode  out  6  instr[31:26], to decoder
func  out  6  instr[5:0], to decoder
instr_valid  out  1  instr/pc valid for decode and execute
pc  out  32  address of current instruction
pc_plus4  out  32  pc + 4
ex_done  in  1  execute finished; pc_sel/br_taken/jr_target valid
pc_sel  in  2  next-PC select: 00 NEWPC, 01 BRANCH, 10 JUMP, 11 JR
br_taken  in  1  branch condition result from ALU
jr_target  in  32  rs value for JR
addr_err  out  1  sticky misaligned-target flag
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values, applied at the clock edge while rst=1, from any state:
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, addr_err=0, instr_count=0.
  - Any pending fetch or issue is abandoned.
- FSM states IDLE, FETCH, ISSUE, HALT:
  - IDLE: outputs quiet; next cycle goes to FETCH unconditionally.
  - FETCH:
    - imem_req=1; imem_addr=pc, held stable until gnt.
    - On imem_gnt=1: instr<=imem_rdata, then go to ISSUE.
    - Minimum latency: gnt in the first FETCH cycle gives instr_valid=1 on the next cycle.
    - Wait states are unbounded.
  - ISSUE:
    - instr_valid=1; instr and pc are held stable.
    - On ex_done=1: instr_count increments, wrapping mod 2^CNT_W, and next PC is computed from pc_sel.
    - 00: pc+4.
    - 01: if br_taken, pc+4+(sext(instr[15:0])<<2); otherwise pc+4.
    - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
    - 11: jr_target.
    - If next[1:0]==0: pc<=next, instr_valid<=0, go to FETCH.
    - Else: addr_err<=1, pc unchanged, go to HALT.
  - HALT: imem_req=0, instr_valid=0; stays here until rst.
- opcode and func are pure slices of instr.
- All PC arithmetic is mod 2^32: 32'hFFFF_FFFC + 4 = 0. Branch offset sign-extends, so 16'h8000 means -131072 bytes.
- imem_gnt is ignored outside FETCH; imem_rdata is sampled only on gnt.
- ex_done is ignored outside ISSUE. pc_sel, br_taken and jr_target are sampled only on ex_done.
- ex_done and imem_gnt together in the same cycle: only the input relevant to the current state acts.
- rst together with gnt or ex_done: reset wins; no capture, no count.
- The counter increments even when the target is misaligned, since that instruction retired.

Decomposition:
- PC_MUX_SEL_NEWPC/BRANCH/JUMP/JR encodings (00/01/10/11) belong in the shared ctrl_encode_def.v.
- FSM state encodings stay local.
- Natural sub-module: npc_calc, combinational.
  - Inputs: pc, instr, pc_sel, br_taken, jr_target.
  - Outputs: next_pc and misaligned.

Test Plan:
- Reset, then release with RESET_PC=0 and gnt returned after 2 wait cycles, rdata=32'h3403_0005 (ori) -> imem_req high for 3 cycles with imem_addr=0; next cycle instr_valid=1, opcode=6'h0D, func=6'h05.
- ex_done with pc_sel=00 at pc=0 -> pc=4, instr_count=1, new fetch at 4.
- At pc=32'h40 with instr imm=16'hFFFF, pc_sel=01, br_taken=1 -> pc=32'h40; with br_taken=0 -> pc=32'h44.
- At pc=32'h0040_0010 with instr[25:0]=26'h10_0000 and pc_sel=10 -> pc=32'h0040_0000. Also at pc=32'hFFFF_FFFC with pc_sel=00 -> pc=0.
- pc_sel=11 with jr_target=32'h0000_1002 -> addr_err=1, HALT; gnt and ex_done afterwards cause no change; instr_count still increments once.
- rst asserted in FETCH while gnt=1 -> instr stays 0, pc=RESET_PC, state IDLE, addr_err cleared.
